// File: rtl/sc_tx_port_arbiter_pkg.sv
// Shared serial-interface-engine constants for the transmit-port arbiter:
// FSM state encodings, requester indices, transmit control codes and small
// index helpers used by the arbiter top and its selection sub-module.
package sc_tx_port_arbiter_pkg;

  // Arbiter FSM state encodings (2-bit).
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_OWNED = 2'd1;
  localparam logic [1:0] ARB_GAP   = 2'd2;

  // Requester indices on the shared transmit port.
  localparam logic [1:0] REQ_SEND_PKT   = 2'd0;
  localparam logic [1:0] REQ_DIRECT_CTL = 2'd1;
  localparam logic [1:0] REQ_SPARE      = 2'd2;

  // Control codes carried on SCTxPortCntl toward the SIE.
  localparam logic [7:0] TX_PACKET_START  = 8'h01;
  localparam logic [7:0] TX_PACKET_STREAM = 8'h02;
  localparam logic [7:0] TX_PACKET_STOP   = 8'h03;

  // One transmit beat as presented by a requester.
  typedef struct packed {
    logic       wen;
    logic [7:0] data;
    logic [7:0] cntl;
  } tx_beat_t;

  // Requester index to one-hot grant vector; out-of-range maps to no grant.
  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    oh = 3'b000;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Next requester index, modulo 3.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/sc_tx_port_arbiter_if.sv
// Bundle of the three requester ports, the merged SIE transmit port and the
// arbiter's status/debug outputs.
//
// Handshake: a requester raises reqN and holds it for its whole packet.
// gntN is registered and rises on the first edge that samples reqN while the
// arbiter is idle; it stays high for as long as reqN stays high and falls on
// the edge that samples reqN low. wenN/dataN/cntlN are passed to the merged
// port combinationally only while gntN is high; a wenN pulse without gntN
// (outside the post-release gap of the previous owner) sets wenErr.
interface sc_tx_port_arbiter_if;
  logic       req0, req1, req2;
  logic       gnt0, gnt1, gnt2;
  logic       wen0, wen1, wen2;
  logic [7:0] data0, data1, data2;
  logic [7:0] cntl0, cntl1, cntl2;
  logic       SCTxPortWEn;
  logic [7:0] SCTxPortData;
  logic [7:0] SCTxPortCntl;
  logic       wenErr;
  logic [1:0] arb_state;

  // Arbiter side.
  modport slave (
    input  req0, req1, req2,
    input  wen0, wen1, wen2,
    input  data0, data1, data2,
    input  cntl0, cntl1, cntl2,
    output gnt0, gnt1, gnt2,
    output SCTxPortWEn, SCTxPortData, SCTxPortCntl,
    output wenErr, arb_state
  );

  // Requester / SIE side.
  modport master (
    output req0, req1, req2,
    output wen0, wen1, wen2,
    output data0, data1, data2,
    output cntl0, cntl1, cntl2,
    input  gnt0, gnt1, gnt2,
    input  SCTxPortWEn, SCTxPortData, SCTxPortCntl,
    input  wenErr, arb_state
  );
endinterface

// File: rtl/sc_tx_arb_select.sv
// Next-owner selection for the transmit-port arbiter. Pure combinational.
// Default: fixed priority req0 > req1 > req2.
// SC_TX_ARB_ROUND_ROBIN_EN: rotating priority (last+1), (last+2), last.
module sc_tx_arb_select
  import sc_tx_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
`ifdef SC_TX_ARB_ROUND_ROBIN_EN
  input  logic [1:0] last,
`endif
  output logic       valid,
  output logic [1:0] sel
);

`ifdef SC_TX_ARB_ROUND_ROBIN_EN
  logic [1:0] first_idx;
  logic [1:0] second_idx;
  logic [1:0] third_idx;

  assign first_idx  = next_idx(last);
  assign second_idx = next_idx(first_idx);
  // Equals last for any legal pointer; keeps an out-of-range pointer legal.
  assign third_idx  = next_idx(second_idx);

  // Scan requesters starting just after the previous owner.
  always_comb begin
    valid = |req;
    sel   = third_idx;
    if (|(req & idx_to_onehot(first_idx))) begin
      sel = first_idx;
    end else if (|(req & idx_to_onehot(second_idx))) begin
      sel = second_idx;
    end
  end
`else
  // Lowest index wins.
  always_comb begin
    valid = |req;
    sel   = REQ_SPARE;
    if (req[0]) begin
      sel = REQ_SEND_PKT;
    end else if (req[1]) begin
      sel = REQ_DIRECT_CTL;
    end
  end
`endif

endmodule

// File: rtl/sc_tx_port_arbiter.sv
// Transmit-port arbiter: grants one of three requesters (send-packet,
// direct-control, spare) access to the shared SIE transmit port, merges the
// owner's write enable/data/control onto the port and flags stray writes.
// After each release an idle gap of GAP_CYCLES (0..3) cycles is enforced.
// Optional macro SC_TX_ARB_ROUND_ROBIN_EN selects rotating priority and adds
// the last-owner pointer register; without it priority is fixed.
module sc_tx_port_arbiter
  import sc_tx_port_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES = 1
)
(
  input  logic                  clk,
  input  logic                  rst,
  sc_tx_port_arbiter_if.slave   bus
);

  // Value loaded into the gap counter when the gap starts.
  localparam logic [1:0] GAP_LOAD = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

  logic [2:0] req_v;
  logic [2:0] wen_v;
  tx_beat_t   beat0, beat1, beat2;
  tx_beat_t   tx_out;

  logic [1:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [2:0] gnt_q,   gnt_d;
  logic [1:0] cnt_q,   cnt_d;
  logic       werr_q,  werr_d;

  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       owner_holds;
  logic [2:0] gap_block;

  assign req_v = {bus.req2, bus.req1, bus.req0};
  assign wen_v = {bus.wen2, bus.wen1, bus.wen0};
  assign beat0 = '{wen: bus.wen0, data: bus.data0, cntl: bus.cntl0};
  assign beat1 = '{wen: bus.wen1, data: bus.data1, cntl: bus.cntl1};
  assign beat2 = '{wen: bus.wen2, data: bus.data2, cntl: bus.cntl2};

  // The current owner is still requesting (gnt_q is one-hot or zero).
  assign owner_holds = |(gnt_q & req_v);

`ifdef SC_TX_ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;

  sc_tx_arb_select u_select (
    .req   (req_v),
    .last  (last_q),
    .valid (sel_valid),
    .sel   (sel_idx)
  );

  // Last-owner pointer follows every new grant.
  always_comb begin
    last_d = last_q;
    if (state_q == ARB_IDLE && sel_valid) begin
      last_d = sel_idx;
    end
  end

  // Pointer register; reset points at the spare port so req0 leads first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_SPARE;
    end else begin
      last_q <= last_d;
    end
  end
`else
  sc_tx_arb_select u_select (
    .req   (req_v),
    .valid (sel_valid),
    .sel   (sel_idx)
  );
`endif

  // Arbiter FSM: grant from idle, hold until release, then enforce the gap.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          state_d = ARB_OWNED;
          owner_d = sel_idx;
          gnt_d   = idx_to_onehot(sel_idx);
        end
      end
      ARB_OWNED: begin
        if (!owner_holds) begin
          gnt_d = 3'b000;
          if (GAP_CYCLES == 0) begin
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_GAP;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      ARB_GAP: begin
        // owner_q keeps the previous owner so its trailing wen can be masked.
        if (cnt_q == 2'd0) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = 3'b000;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // During the gap the previous owner's write enable is tolerated silently.
  assign gap_block = (state_q == ARB_GAP) ? idx_to_onehot(owner_q) : 3'b000;

  // Sticky error on any write enable seen without the matching grant.
  always_comb begin
    werr_d = werr_q | (|(wen_v & ~gnt_q & ~gap_block));
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= REQ_SEND_PKT;
      gnt_q   <= 3'b000;
      cnt_q   <= 2'd0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      werr_q  <= werr_d;
    end
  end

  // Merged transmit port: owner's beat passes straight through, else zero.
  always_comb begin
    tx_out = '0;
    if (gnt_q[0]) begin
      tx_out = beat0;
    end else if (gnt_q[1]) begin
      tx_out = beat1;
    end else if (gnt_q[2]) begin
      tx_out = beat2;
    end
  end

  assign bus.gnt0         = gnt_q[0];
  assign bus.gnt1         = gnt_q[1];
  assign bus.gnt2         = gnt_q[2];
  assign bus.SCTxPortWEn  = tx_out.wen;
  assign bus.SCTxPortData = tx_out.data;
  assign bus.SCTxPortCntl = tx_out.cntl;
  assign bus.wenErr       = werr_q;
  assign bus.arb_state    = state_q;

endmodule
